// File: rtl/weight_bank_loader_if.sv
// rtl/weight_bank_loader_if.sv - shared read port from the weight loader to its bank of weight ROMs
interface weight_bank_loader_if #(
  parameter int KERNEL_WIDTH = 72,
  parameter int NUM_BANKS    = 4,
  parameter int ADDR_WIDTH   = 10
);
  logic                              o_rom_en;
  logic [ADDR_WIDTH-1:0]             o_rom_addr;
  logic [NUM_BANKS*KERNEL_WIDTH-1:0] i_rom_data;

  modport master (output o_rom_en, output o_rom_addr, input  i_rom_data);
  modport slave  (input  o_rom_en, input  o_rom_addr, output i_rom_data);
endinterface

// File: rtl/weight_bank_loader.sv
// rtl/weight_bank_loader.sv - double-buffered kernel loader: prefetches kernels from the banked ROMs into a shadow
// file, then swaps the whole shadow file into the active file in one cycle when the datapath is not holding
module weight_bank_loader #(
  parameter int KERNEL_WIDTH = 72,
  parameter int NUM_BANKS    = 4,
  parameter int KPB          = 3,
  parameter int ADDR_WIDTH   = 10,
  parameter int ROM_LAT      = 2
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  i_start,
  input  logic [ADDR_WIDTH-1:0]                 i_base_addr,
  input  logic                                  i_hold,
  input  logic                                  i_abort,
  weight_bank_loader_if.master                  rom,
  output logic [NUM_BANKS*KPB*KERNEL_WIDTH-1:0] o_kernels,
  output logic                                  o_ready,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic                                  o_start_drop
);
  localparam int KW = KERNEL_WIDTH;
  localparam int NK = NUM_BANKS * KPB;
  localparam int TW = (KPB > 1) ? $clog2(KPB) : 1;
  localparam logic [TW-1:0] LAST_TAG = TW'(KPB - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_SWAP} state_t;

  state_t          state;
  logic [TW-1:0]   k;
  logic [KW-1:0]   shadow [NK];
  logic [ROM_LAT-1:0] pipe_vld;
  logic [TW-1:0]   pipe_tag [ROM_LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      k              <= '0;
      rom.o_rom_en   <= 1'b0;
      rom.o_rom_addr <= '0;
      o_kernels      <= '0;
      o_ready        <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_start_drop   <= 1'b0;
      pipe_vld       <= '0;
      for (int i = 0; i < ROM_LAT; i++) pipe_tag[i] <= '0;
      for (int i = 0; i < NK; i++) shadow[i] <= '0;
    end else begin
      o_done       <= 1'b0;
      o_start_drop <= i_start && (state != S_IDLE);

      // The tag leaving the pipe names the kernel slot that the ROM data on this edge belongs to.
      if (pipe_vld[ROM_LAT-1]) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          for (int t = 0; t < KPB; t++) begin
            if (pipe_tag[ROM_LAT-1] == TW'(t))
              shadow[b*KPB+t] <= rom.i_rom_data[b*KW +: KW];
          end
        end
      end
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      pipe_vld[0] <= (state == S_FETCH);
      pipe_tag[0] <= k;

      if (i_abort) begin
        state        <= S_IDLE;
        rom.o_rom_en <= 1'b0;
        o_busy       <= 1'b0;
        pipe_vld     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start) begin
              state          <= S_FETCH;
              k              <= '0;
              rom.o_rom_addr <= i_base_addr;
              rom.o_rom_en   <= 1'b1;
              o_busy         <= 1'b1;
            end
          end
          S_FETCH: begin
            if (k == LAST_TAG) begin
              state        <= S_DRAIN;
              rom.o_rom_en <= 1'b0;
            end else begin
              k              <= k + 1'b1;
              rom.o_rom_addr <= rom.o_rom_addr + 1'b1;
            end
          end
          S_DRAIN: begin
            if (pipe_vld[ROM_LAT-1] && (pipe_tag[ROM_LAT-1] == LAST_TAG))
              state <= S_SWAP;
          end
          S_SWAP: begin
            if (!i_hold) begin
              for (int i = 0; i < NK; i++) o_kernels[i*KW +: KW] <= shadow[i];
              o_done  <= 1'b1;
              o_ready <= 1'b1;
              o_busy  <= 1'b0;
              state   <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_weight_bank_loader.sv
// tb/tb_weight_bank_loader.sv - directed bench for weight_bank_loader at the defaults and two latency sweeps
module tb_weight_bank_loader;
  localparam int KW = 72;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rstn;
  logic i_start, i_hold, i_abort;
  logic [AW-1:0] i_base_addr;

  always #5 clk = ~clk;

  weight_bank_loader_if #(.KERNEL_WIDTH(KW), .NUM_BANKS(4), .ADDR_WIDTH(AW)) rom0 ();
  weight_bank_loader_if #(.KERNEL_WIDTH(KW), .NUM_BANKS(2), .ADDR_WIDTH(AW)) rom1 ();
  weight_bank_loader_if #(.KERNEL_WIDTH(KW), .NUM_BANKS(2), .ADDR_WIDTH(AW)) rom4 ();

  logic [4*3*KW-1:0] k0;
  logic [2*5*KW-1:0] k1, k4;
  logic rdy0, bsy0, dn0, drp0;
  logic rdy1, bsy1, dn1, drp1;
  logic rdy4, bsy4, dn4, drp4;

  weight_bank_loader #(.KERNEL_WIDTH(KW), .NUM_BANKS(4), .KPB(3), .ADDR_WIDTH(AW), .ROM_LAT(2)) u_dut0 (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_base_addr(i_base_addr), .i_hold(i_hold),
    .i_abort(i_abort), .rom(rom0), .o_kernels(k0), .o_ready(rdy0), .o_busy(bsy0),
    .o_done(dn0), .o_start_drop(drp0));
  weight_bank_loader #(.KERNEL_WIDTH(KW), .NUM_BANKS(2), .KPB(5), .ADDR_WIDTH(AW), .ROM_LAT(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_base_addr(i_base_addr), .i_hold(i_hold),
    .i_abort(i_abort), .rom(rom1), .o_kernels(k1), .o_ready(rdy1), .o_busy(bsy1),
    .o_done(dn1), .o_start_drop(drp1));
  weight_bank_loader #(.KERNEL_WIDTH(KW), .NUM_BANKS(2), .KPB(5), .ADDR_WIDTH(AW), .ROM_LAT(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_base_addr(i_base_addr), .i_hold(i_hold),
    .i_abort(i_abort), .rom(rom4), .o_kernels(k4), .o_ready(rdy4), .o_busy(bsy4),
    .o_done(dn4), .o_start_drop(drp4));

  function automatic logic [KW-1:0] exp_k(input int b, input logic [AW-1:0] a);
    return (KW'(b) << 16) | KW'(a);
  endfunction

  // ROM models: bank b returns {b, addr}, delayed by each instance's read latency.
  logic [AW-1:0] a0 [2];
  logic [AW-1:0] a1;
  logic [AW-1:0] a4 [4];
  always @(posedge clk) begin
    a0[0] <= rom0.o_rom_addr;
    a0[1] <= a0[0];
    a1    <= rom1.o_rom_addr;
    a4[0] <= rom4.o_rom_addr;
    for (int i = 1; i < 4; i++) a4[i] <= a4[i-1];
  end
  always_comb begin
    rom0.i_rom_data = '0;
    rom1.i_rom_data = '0;
    rom4.i_rom_data = '0;
    for (int b = 0; b < 4; b++) rom0.i_rom_data[b*KW +: KW] = exp_k(b, a0[1]);
    for (int b = 0; b < 2; b++) rom1.i_rom_data[b*KW +: KW] = exp_k(b, a1);
    for (int b = 0; b < 2; b++) rom4.i_rom_data[b*KW +: KW] = exp_k(b, a4[3]);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int dn0_cyc, dn1_cyc, dn4_cyc, dn0_cnt, drp_cyc, drp4_cyc, reads0, first_read, kchg_cyc, kchg_cnt;
  int addr_q[$];
  logic [4*3*KW-1:0] kprev;

  task automatic start_load(input logic [AW-1:0] base);
    @(posedge clk); #1;
    i_start     = 1'b1;
    i_base_addr = base;
  endtask

  task automatic watch(input int ncyc, input int hold_from, input int hold_to, input int abort_at,
                       input int restart_at, input logic [AW-1:0] restart_base);
    dn0_cyc = -1; dn1_cyc = -1; dn4_cyc = -1; dn0_cnt = 0; drp_cyc = -1; drp4_cyc = -1;
    reads0 = 0; first_read = -1; kchg_cyc = -1; kchg_cnt = 0;
    addr_q.delete();
    kprev = k0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      if (dn0) begin
        if (dn0_cyc < 0) dn0_cyc = c;
        dn0_cnt++;
      end
      if (dn1 && dn1_cyc < 0) dn1_cyc = c;
      if (dn4 && dn4_cyc < 0) dn4_cyc = c;
      if (drp0 && drp_cyc < 0) drp_cyc = c;
      if (drp4 && drp4_cyc < 0) drp4_cyc = c;
      if (rom0.o_rom_en) begin
        reads0++;
        if (first_read < 0) first_read = c;
        addr_q.push_back(int'(rom0.o_rom_addr));
      end
      if (k0 !== kprev) begin
        kchg_cnt++;
        kchg_cyc = c;
        kprev = k0;
      end
      i_hold  = (c >= hold_from) && (c <= hold_to);
      i_abort = (c == abort_at);
      i_start = (c == restart_at);
      if (c == restart_at) i_base_addr = restart_base;
    end
    i_hold = 1'b0; i_abort = 1'b0; i_start = 1'b0;
  endtask

  task automatic check_k0(input string tag, input logic [AW-1:0] base);
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 3; k++)
        check($sformatf("%s_k0[%0d]", tag, b*3+k), k0[(b*3+k)*KW +: KW], exp_k(b, base + AW'(k)));
  endtask

  task automatic check_k5(input string tag, input logic [2*5*KW-1:0] kv, input logic [AW-1:0] base);
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < 5; k++)
        check($sformatf("%s[%0d]", tag, b*5+k), kv[(b*5+k)*KW +: KW], exp_k(b, base + AW'(k)));
  endtask

  initial begin
    rstn = 1'b0; i_start = 1'b0; i_hold = 1'b0; i_abort = 1'b0; i_base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_kernels", KW'(|k0), 0);
    check("rst_ready", KW'(rdy0), 0);
    check("rst_busy", KW'(bsy0), 0);
    check("rst_done", KW'(dn0), 0);
    check("rst_drop", KW'(drp0), 0);
    check("rst_rom_en", KW'(rom0.o_rom_en), 0);
    rstn = 1'b1;

    // basic load at defaults, plus latency sweeps on the 2-bank, 5-kernel instances
    start_load(10'h010);
    watch(16, -1, -1, -1, -1, '0);
    check("t1_done_cyc", dn0_cyc, 7);
    check("t1_done_cnt", dn0_cnt, 1);
    check("t1_first_read", first_read, 1);
    check("t1_reads", reads0, 3);
    for (int i = 0; i < 3; i++) check($sformatf("t1_addr%0d", i), addr_q[i], 'h010 + i);
    check("t1_kchg_cyc", kchg_cyc, 7);
    check("t1_ready", KW'(rdy0), 1);
    check("t1_busy", KW'(bsy0), 0);
    check_k0("t1", 10'h010);
    check("lat1_done_cyc", dn1_cyc, 8);
    check("lat4_done_cyc", dn4_cyc, 11);
    check_k5("lat1_k", k1, 10'h010);
    check_k5("lat4_k", k4, 10'h010);

    // hold over the swap window
    start_load(10'h020);
    watch(20, 4, 11, -1, -1, '0);
    check("t2_done_cyc", dn0_cyc, 13);
    check("t2_kchg_cyc", kchg_cyc, 13);
    check("t2_kchg_cnt", kchg_cnt, 1);
    check_k0("t2", 10'h020);

    // address wrap
    start_load(10'h3FF);
    watch(16, -1, -1, -1, -1, '0);
    check("t3_addr0", addr_q[0], 'h3FF);
    check("t3_addr1", addr_q[1], 'h000);
    check("t3_addr2", addr_q[2], 'h001);
    check_k0("t3", 10'h3FF);
    check_k5("t3_lat4_k", k4, 10'h3FF);

    // second start while busy is dropped
    start_load(10'h100);
    watch(16, -1, -1, -1, 2, 10'h200);
    check("t4_drop_cyc", drp_cyc, 3);
    check("t4_lat4_drop_cyc", drp4_cyc, 3);
    check("t4_reads", reads0, 3);
    check("t4_done_cyc", dn0_cyc, 7);
    check_k0("t4", 10'h100);

    // abort mid-fetch keeps the previous layer
    start_load(10'h040);
    watch(16, -1, -1, 3, -1, '0);
    check("t5_done_cyc", dn0_cyc, -1);
    check("t5_lat4_done_cyc", dn4_cyc, -1);
    check("t5_kchg_cnt", kchg_cnt, 0);
    check("t5_ready", KW'(rdy0), 1);
    check("t5_busy", KW'(bsy0), 0);
    check_k0("t5", 10'h100);

    // start and abort together in idle
    @(posedge clk); #1;
    i_start = 1'b1; i_abort = 1'b1; i_base_addr = 10'h070;
    watch(4, -1, -1, -1, -1, '0);
    check("t5b_drop", drp_cyc, -1);
    check("t5b_reads", reads0, 0);
    check("t5b_busy", KW'(bsy0), 0);

    start_load(10'h050);
    watch(16, -1, -1, -1, -1, '0);
    check("t5c_done_cyc", dn0_cyc, 7);
    check("t5c_lat1_done_cyc", dn1_cyc, 8);
    check_k0("t5c", 10'h050);
    check_k5("t5c_lat1_k", k1, 10'h050);

    // asynchronous reset mid-fetch
    start_load(10'h060);
    watch(2, -1, -1, -1, -1, '0);
    check("t6_pre_rom_en", KW'(rom0.o_rom_en), 1);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rom_en", KW'(rom0.o_rom_en), 0);
    check("t6_busy", KW'(bsy0), 0);
    check("t6_ready", KW'(rdy0), 0);
    check("t6_kernels", KW'(|k0), 0);
    check("t6_lat1_rom_en", KW'(rom1.o_rom_en), 0);
    check("t6_lat1_ready", KW'(rdy1), 0);
    check("t6_lat1_busy", KW'(bsy1), 0);
    check("t6_lat1_kernels", KW'(|k1), 0);
    check("t6_lat4_ready", KW'(rdy4), 0);
    check("t6_lat4_busy", KW'(bsy4), 0);
    check("t6_lat4_kernels", KW'(|k4), 0);
    check("t6_lat1_drop", KW'(drp1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
